spi_slot_drainer: RTL and testbench

- SPI-side engine of the AXI4-Lite to SPI bridge.
- Scans the per-slot write-status bits for slots 16..31 and serves one full slot at a time:
  - fetches the slot's buffered byte;
  - runs a 16-bit SPI mode-0 frame (slot address byte, then data byte);
  - stores the byte returned on MISO into the read buffer.
- On completion it pulses the write-status clear and the read-status valid update for that slot. This closes the loop the AXI write path opens.

---
 rtl/spi_slot_drainer.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slot_drainer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slot_drainer.sv
// SPI-side drain engine: picks full write slots 16..31 round-robin, shifts out
// {slot, byte} as a mode-0 frame, stores the MISO byte and retires the slot.
module spi_slot_drainer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] full_vec,
  output logic [7:0]  bufRdAddr,
  input  logic [7:0]  bufRdData,
  output logic        wrStatUpEn,
  output logic [7:0]  wrStatUpAddr,
  output logic        rspWrEn,
  output logic [7:0]  rspWrAddr,
  output logic [7:0]  rspWrData,
  output logic        rdStatUpEn,
  output logic [7:0]  rdStatUpAddr,
  output logic        rdStatUp,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned IDX_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] fall_q, fall_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic [15:0]      shift_q, shift_d;
  logic [7:0]       rx_q, rx_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [7:0]       rd_addr_q, rd_addr_d;
  logic             upd_q, upd_d;
  logic [7:0]       upd_addr_q, upd_addr_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_ok_c;
  logic [IDX_W-1:0] cand_c;
  logic [7:0]       slot_c;

  assign slot_c = {4'h1, idx_q};

  // Round-robin search: first full slot at or after rr, wrapping 15 -> 0.
  always_comb begin
    pick_idx_c = '0;
    pick_ok_c  = 1'b0;
    cand_c     = '0;
    for (int k = 0; k < 16; k++) begin
      cand_c = rr_q + IDX_W'(k);
      if (!pick_ok_c && full_vec[cand_c]) begin
        pick_ok_c  = 1'b1;
        pick_idx_c = cand_c;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    fall_d     = fall_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    rd_addr_d  = rd_addr_q;
    upd_d      = 1'b0;
    upd_addr_d = upd_addr_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_ok_c) begin
          idx_d     = pick_idx_c;
          rd_addr_d = {4'h1, pick_idx_c};
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: state_d = ST_LOAD;

      ST_LOAD: begin
        shift_d = {slot_c, bufRdData};
        cs_n_d  = 1'b0;
        mosi_d  = slot_c[7];
        sclk_d  = 1'b0;
        div_d   = '0;
        fall_d  = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], miso};
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            mosi_d  = shift_q[14];
            fall_d  = fall_q + BIT_W'(1);
            // Strobes and their payload go out together in the DONE cycle.
            if (fall_q == BIT_W'(15)) begin
              upd_d      = 1'b1;
              upd_addr_d = slot_c;
              rsp_data_d = rx_q;
              state_d    = ST_DONE;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        cs_n_d  = 1'b1;
        rr_d    = idx_q + IDX_W'(1);
        div_d   = '0;
        state_d = ST_GAP;
      end

      ST_GAP: begin
        // Lets the cleared write status settle before the next scan.
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      fall_q     <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      shift_q    <= '0;
      rx_q       <= '0;
      idx_q      <= '0;
      rr_q       <= '0;
      rd_addr_q  <= '0;
      upd_q      <= 1'b0;
      upd_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      fall_q     <= fall_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      rd_addr_q  <= rd_addr_d;
      upd_q      <= upd_d;
      upd_addr_q <= upd_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bufRdAddr    = rd_addr_q;
  assign wrStatUpEn   = upd_q;
  assign rspWrEn      = upd_q;
  assign rdStatUpEn   = upd_q;
  assign rdStatUp     = upd_q;
  assign wrStatUpAddr = upd_addr_q;
  assign rspWrAddr    = upd_addr_q;
  assign rdStatUpAddr = upd_addr_q;
  assign rspWrData    = rsp_data_q;
  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;

endmodule

// File: tb/tb_spi_slot_drainer.sv
// Bench for spi_slot_drainer: write-buffer and SPI slave models, round-robin reference.
module tb_spi_slot_drainer;

  localparam int unsigned CD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] full_vec = '0;
  logic [7:0]  bufRdAddr;
  logic [7:0]  bufRdData = '0;
  logic        wrStatUpEn, rspWrEn, rdStatUpEn, rdStatUp;
  logic [7:0]  wrStatUpAddr, rspWrAddr, rdStatUpAddr, rspWrData;
  logic        cs_n, sclk, mosi;
  logic        miso = 1'b0;

  logic [7:0]  mem [16];
  int          checks = 0;
  int          failures = 0;
  int          strobe_cnt = 0;
  logic        force_en = 1'b0;
  logic [7:0]  force_val = '0;
  logic [7:0]  slave_rsp = '0;
  logic [15:0] slv_tx = '0;
  logic        slv_act = 1'b0;
  logic [15:0] mfv = '0;
  logic [3:0]  mrr = '0;

  spi_slot_drainer #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .full_vec(full_vec),
    .bufRdAddr(bufRdAddr), .bufRdData(bufRdData),
    .wrStatUpEn(wrStatUpEn), .wrStatUpAddr(wrStatUpAddr),
    .rspWrEn(rspWrEn), .rspWrAddr(rspWrAddr), .rspWrData(rspWrData),
    .rdStatUpEn(rdStatUpEn), .rdStatUpAddr(rdStatUpAddr), .rdStatUp(rdStatUp),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Registered write-buffer read port.
  always @(posedge clk) bufRdData <= mem[bufRdAddr[3:0]];

  // Mode-0 slave: first bit valid at cs_n fall, next bit after each falling sclk.
  always @(negedge cs_n or negedge sclk or posedge cs_n) begin
    if (cs_n) begin
      slv_act = 1'b0;
    end else if (!slv_act) begin
      slv_tx    = force_en ? {8'h00, force_val} : 16'($urandom);
      slave_rsp = slv_tx[7:0];
      miso      = slv_tx[15];
      slv_act   = 1'b1;
    end else begin
      slv_tx = {slv_tx[14:0], 1'b0};
      miso   = slv_tx[15];
    end
  end

  always @(negedge clk) if (wrStatUpEn || rspWrEn || rdStatUpEn) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] fv, input logic [3:0] rr);
    for (int k = 0; k < 16; k++)
      if (fv[(int'(rr) + k) % 16]) return (int'(rr) + k) % 16;
    return -1;
  endfunction

  // Observe one complete frame for slot 16+idx and retire it in the status model.
  task automatic serve(input logic [3:0] idx, input bit refill, input bit chk_gap,
                       input int drop_rise, output logic [15:0] mw, output logic [7:0] rsp);
    int t, gap, cyc, nr, nf, flen;
    logic ps;
    logic [7:0] slot;
    logic [15:0] exp_mw;
    slot = {4'h1, idx};
    exp_mw = {slot, mem[idx]};
    t = 0; gap = 1; mw = '0; rsp = '0;
    do begin
      @(negedge clk); t++;
      if (cs_n === 1'b1) gap++;
    end while (cs_n !== 1'b0 && t < 3000);
    check("cs_fall", 32'(cs_n), 32'd0);
    if (cs_n !== 1'b0) return;
    if (chk_gap) check("cs_gap_min", 32'(gap >= int'(CD + 2)), 32'd1);
    cyc = 0; nr = 0; nf = 0; flen = 0; ps = sclk;
    while (wrStatUpEn !== 1'b1 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (sclk === 1'b1 && ps === 1'b0) begin
        nr++;
        mw = {mw[14:0], mosi};
        if (nr == drop_rise) full_vec[idx] = 1'b0;
      end
      if (sclk === 1'b0 && ps === 1'b1) begin
        nf++;
        if (nf == 16) flen = cyc;
      end
      ps = sclk;
    end
    rsp = rspWrData;
    check("strobe_wr", 32'(wrStatUpEn), 32'd1);
    check("strobe_rsp", 32'(rspWrEn), 32'd1);
    check("strobe_rd", 32'(rdStatUpEn), 32'd1);
    check("rd_stat_val", 32'(rdStatUp), 32'd1);
    check("wr_stat_addr", 32'(wrStatUpAddr), 32'(slot));
    check("rsp_addr", 32'(rspWrAddr), 32'(slot));
    check("rd_stat_addr", 32'(rdStatUpAddr), 32'(slot));
    check("buf_addr", 32'(bufRdAddr), 32'(slot));
    check("rsp_data", 32'(rspWrData), 32'(slave_rsp));
    check("mosi_word", 32'(mw), 32'(exp_mw));
    check("sclk_rises", 32'(nr), 32'd16);
    check("sclk_falls", 32'(nf), 32'd16);
    check("frame_len", 32'(flen), 32'(32 * CD));
    check("sclk_low_done", 32'(sclk), 32'd0);
    if (refill) mem[idx] = 8'($urandom);
    else full_vec[idx] = 1'b0;
    @(negedge clk);
    check("strobe_width", 32'({wrStatUpEn, rspWrEn, rdStatUpEn}), 32'd0);
    check("cs_rise", 32'(cs_n), 32'd1);
  endtask

  task automatic run(input int n, input logic [15:0] refill);
    int j;
    logic [15:0] mw;
    logic [7:0] rs;
    for (int f = 0; f < n; f++) begin
      j = pick(mfv, mrr);
      if (j < 0) break;
      serve(4'(j), refill[j], f > 0, 0, mw, rs);
      mrr = 4'(j + 1);
      if (!refill[j]) mfv[j] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mrr = '0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mw;
    logic [7:0] rs;
    logic [15:0] fv, rf;
    int t, nr, cnt0, pc;
    logic ps;

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_buf_addr", 32'(bufRdAddr), 32'd0);
    check("rst_strobes", 32'({wrStatUpEn, rspWrEn, rdStatUpEn, rdStatUp}), 32'd0);
    check("rst_addrs", 32'({wrStatUpAddr, rspWrAddr, rdStatUpAddr, rspWrData}), 32'd0);
    check("rst_strobe_cnt", 32'(strobe_cnt), 32'd0);

    // Single slot, fixed data and response.
    mem[0] = 8'hA5; force_en = 1'b1; force_val = 8'h3C;
    full_vec = 16'h0001; mfv = 16'h0001;
    serve(4'd0, 1'b0, 1'b0, 0, mw, rs);
    mfv[0] = 1'b0; mrr = 4'd1;
    check("single_mosi", 32'(mw), 32'h10A5);
    check("single_rsp", 32'(rs), 32'h3C);
    force_en = 1'b0;

    // Round-robin from rr=0, then a refilled slot 16 after the wrap.
    pulse_reset();
    full_vec = 16'h8003; mfv = 16'h8003;
    run(3, 16'h0000);
    check("rr_drained", 32'(full_vec), 32'd0);
    full_vec[0] = 1'b1; mfv[0] = 1'b1;
    run(1, 16'h0000);

    // Starvation: 16 and 20 both kept full must alternate.
    full_vec = 16'h0011; mfv = 16'h0011;
    run(4, 16'h0011);
    run(16, 16'h0000);

    // Full bit drops mid-frame.
    full_vec = 16'h0040; mfv = 16'h0040;
    serve(4'd6, 1'b0, 1'b0, 3, mw, rs);
    mfv[6] = 1'b0; mrr = 4'd7;

    // Reset after the 5th rising SCLK edge.
    repeat (CD + 4) @(negedge clk);
    cnt0 = strobe_cnt;
    full_vec = 16'h0001; mfv = 16'h0001;
    t = 0; nr = 0; ps = sclk;
    while (nr < 5 && t < 2000) begin
      @(negedge clk); t++;
      if (sclk === 1'b1 && ps === 1'b0) nr++;
      ps = sclk;
    end
    check("rstmid_rises", 32'(nr), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_cs_n", 32'(cs_n), 32'd1);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; mrr = '0;
    check("rstmid_no_strobe", 32'(strobe_cnt), 32'(cnt0));
    check("rstmid_not_cleared", 32'(full_vec), 32'h0001);
    run(1, 16'h0000);

    // Randomized rounds; one round with all 16 slots full.
    for (int r = 0; r < 6; r++) begin
      fv = 16'($urandom) & 16'($urandom);
      if (fv == 16'h0000) fv = 16'h0100;
      if (r == 3) fv = 16'hFFFF;
      rf = (r == 3) ? 16'h0000 : (fv & 16'($urandom));
      pc = $countones(fv);
      full_vec = fv; mfv = fv;
      run(pc + 3, rf);
      run(40, 16'h0000);
      check("round_drained", 32'(full_vec), 32'd0);
    end

    repeat (10) @(negedge clk);
    check("final_cs_n", 32'(cs_n), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
